x9_run_sequencer: RTL and testbench
===================================

// Module: x9_run_sequencer
// PURPOSE
//  Parametrised successor to the X9 single-cycle fetch path: owns the program counter, branch-target LUT,
//  lagging ALU flag registers (one/pari/sc) and a req/done run-control handshake. Replaces the fixed
//  "done = prog_ctr==65" and ROM-baked PC_LUT. Sits between the testbench/host and instr_ROM/Control.
// PARAMETERS
//  D       12  program counter width
//  LW      4   LUT index width; LUT holds 2**LW targets of D bits
//  WD_MAX  4095 watchdog cycle limit (used only with X9_WATCHDOG_EN)
// PORTS
//  clk        in   1     clock; all state on posedge
//  reset      in   1     synchronous, active-high
//  req        in   1     run request (4-phase with done)
//  start_addr in   D     PC loaded on run start
//  halt_addr  in   D     PC value that ends the run
//  stall      in   1     hold PC and flags this cycle
//  abs_en     in   1     absolute jump request (BranchInst)
//  rel_en     in   1     relative jump request
//  lut_idx    in   LW    LUT entry for absolute jump (mach_code[LW-1:0])
//  rel_off    in   D     two's-complement relative offset
//  one_in     in   1     ALU one flag
//  pari_in    in   1     ALU parity flag
//  sc_in      in   1     ALU shift/carry out
//  sc_en      in   1     load sc_q from sc_in
//  sc_clr     in   1     clear sc_q (beats sc_en)
//  lut_we     in   1     LUT write strobe
//  lut_waddr  in   LW    LUT write index
//  lut_wdata  in   D     LUT write data
//  prog_ctr   out  D     current PC to instr_ROM
//  one_q      out  1     lagging one flag (branch condition)
//  pari_q     out  1     lagging parity flag
//  sc_q       out  1     lagging shift/carry to ALU sc_i
//  busy       out  1     high in RUN
//  done       out  1     high in DONE
//  timeout    out  1     run ended by watchdog
// BEHAVIOUR
//  Reset: state=IDLE; prog_ctr, one_q, pari_q, sc_q, busy, done, timeout = 0; all LUT entries = 0.
//  Reset mid-run: same values next edge; run is abandoned, no done pulse.
//  FSM IDLE->RUN: req=1 in IDLE; prog_ctr<=start_addr, flags cleared, busy=1 next cycle.
//  RUN, stall=0, priority: (1) prog_ctr==halt_addr -> DONE, PC holds; (2) abs_en&one_q -> PC<=LUT[lut_idx];
//   (3) rel_en&one_q -> PC<=PC+rel_off mod 2**D; (4) PC<=PC+1 mod 2**D (wraps max->0).
//  abs_en and rel_en both taken: absolute wins. Branch with one_q=0: falls through to PC+1.
//  Flags in RUN, stall=0: one_q<=one_in, pari_q<=pari_in; sc_q<=0 if sc_clr else sc_in if sc_en.
//  stall=1: PC and all flags hold; branch requests that cycle ignored (upstream re-presents).
//  Halt check uses registered PC: instruction at halt_addr is fetched, not executed further; halt
//   wins over stall. start_addr==halt_addr -> DONE one cycle after entering RUN.
//  DONE: done=1, busy=0, PC/flags hold; req=0 -> IDLE (done drops next cycle). req still 1 -> stay.
//  IDLE ignores stall/branch/flag inputs; flags hold.
//  LUT: write on posedge when lut_we, any state. Same-cycle write+read of one index reads old value.
// CONFIGURATION
//  X9_WATCHDOG_EN defined: cycle counter clears on RUN entry, counts non-stalled RUN cycles; on reaching
//   WD_MAX without halt -> DONE with timeout=1 (held until IDLE). Halt on same cycle wins, timeout=0.
//  X9_WATCHDOG_EN undefined: no counter, timeout tied 0, WD_MAX unused.
// TESTING
//  Reset, then req=1, start=0, halt=5, no branches -> PC 0,1,2,3,4,5; done=1 at cycle 7; req=0 -> IDLE.
//  LUT[3]=0x040; at PC=2 drive abs_en, lut_idx=3 with one_q=1 -> next PC=0x040; with one_q=0 -> PC=3.
//  rel_en, rel_off=0xFFE at PC=0x010, one_q=1 -> PC=0x00E; PC=0xFFF, no branch -> PC=0x000.
//  stall=1 for 3 cycles at PC=4, one_in toggling -> PC and one_q unchanged; then resumes at 5.
//  reset asserted at PC=7 in RUN -> next cycle PC=0, busy=0, done=0, LUT cleared.
//  X9_WATCHDOG_EN, WD_MAX=10, halt unreachable -> done=1, timeout=1 after 10 RUN cycles.

Source files
------------

// File: rtl/x9_run_sequencer_if.sv
// Run-control, branch, flag and LUT-write signals between host/decoder and x9_run_sequencer.
interface x9_run_sequencer_if #(
    parameter int unsigned D  = 12,
    parameter int unsigned LW = 4
);
    logic          req;
    logic [D-1:0]  start_addr;
    logic [D-1:0]  halt_addr;
    logic          stall;
    logic          abs_en;
    logic          rel_en;
    logic [LW-1:0] lut_idx;
    logic [D-1:0]  rel_off;
    logic          one_in;
    logic          pari_in;
    logic          sc_in;
    logic          sc_en;
    logic          sc_clr;
    logic          lut_we;
    logic [LW-1:0] lut_waddr;
    logic [D-1:0]  lut_wdata;
    logic [D-1:0]  prog_ctr;
    logic          one_q;
    logic          pari_q;
    logic          sc_q;
    logic          busy;
    logic          done;
    logic          timeout;

    modport master (
        output req, start_addr, halt_addr, stall, abs_en, rel_en, lut_idx, rel_off,
               one_in, pari_in, sc_in, sc_en, sc_clr, lut_we, lut_waddr, lut_wdata,
        input  prog_ctr, one_q, pari_q, sc_q, busy, done, timeout
    );

    modport slave (
        input  req, start_addr, halt_addr, stall, abs_en, rel_en, lut_idx, rel_off,
               one_in, pari_in, sc_in, sc_en, sc_clr, lut_we, lut_waddr, lut_wdata,
        output prog_ctr, one_q, pari_q, sc_q, busy, done, timeout
    );
endinterface

// File: rtl/x9_run_sequencer.sv
// X9 program counter, branch-target LUT, lagging ALU flags and req/done run control.
// Optional watchdog enabled by defining X9_WATCHDOG_EN.
module x9_run_sequencer #(
    parameter int unsigned D      = 12,
    parameter int unsigned LW     = 4,
    parameter int unsigned WD_MAX = 4095
) (
    input logic               clk,
    input logic               reset,
    x9_run_sequencer_if.slave bus
);
    localparam int unsigned LutDepth = 2 ** LW;

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e       state_q, state_d;
    logic [D-1:0] pc_q, pc_d;
    logic         one_q, one_d;
    logic         pari_q, pari_d;
    logic         sc_q, sc_d;
    logic         timeout_q, timeout_d;
    logic [D-1:0] lut_q [LutDepth];
    logic         wd_hit;

`ifdef X9_WATCHDOG_EN
    localparam int unsigned WdW = $clog2(WD_MAX + 1);

    logic [WdW-1:0] wd_cnt_q;

    always_ff @(posedge clk) begin
        if (reset || (state_q == StIdle && bus.req)) begin
            wd_cnt_q <= '0;
        end else if (state_q == StRun && !bus.stall) begin
            wd_cnt_q <= wd_cnt_q + WdW'(1);
        end
    end

    // Fires on the WD_MAX-th non-stalled RUN cycle.
    assign wd_hit = (wd_cnt_q == WdW'(WD_MAX - 1));
`else
    assign wd_hit = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        one_d     = one_q;
        pari_d    = pari_q;
        sc_d      = sc_q;
        timeout_d = timeout_q;
        unique case (state_q)
            StIdle: begin
                if (bus.req) begin
                    state_d   = StRun;
                    pc_d      = bus.start_addr;
                    one_d     = 1'b0;
                    pari_d    = 1'b0;
                    sc_d      = 1'b0;
                    timeout_d = 1'b0;
                end
            end
            StRun: begin
                if (!bus.stall) begin
                    one_d  = bus.one_in;
                    pari_d = bus.pari_in;
                    if (bus.sc_clr) begin
                        sc_d = 1'b0;
                    end else if (bus.sc_en) begin
                        sc_d = bus.sc_in;
                    end
                end
                // Halt uses the registered PC and overrides stall and the watchdog.
                if (pc_q == bus.halt_addr) begin
                    state_d = StDone;
                end else if (!bus.stall) begin
                    if (wd_hit) begin
                        state_d   = StDone;
                        timeout_d = 1'b1;
                    end else if (bus.abs_en && one_q) begin
                        pc_d = lut_q[bus.lut_idx];
                    end else if (bus.rel_en && one_q) begin
                        pc_d = pc_q + bus.rel_off;
                    end else begin
                        pc_d = pc_q + D'(1);
                    end
                end
            end
            StDone: begin
                if (!bus.req) begin
                    state_d   = StIdle;
                    timeout_d = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            pc_q      <= '0;
            one_q     <= 1'b0;
            pari_q    <= 1'b0;
            sc_q      <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            one_q     <= one_d;
            pari_q    <= pari_d;
            sc_q      <= sc_d;
            timeout_q <= timeout_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < LutDepth; i++) begin
                lut_q[i] <= '0;
            end
        end else if (bus.lut_we) begin
            lut_q[bus.lut_waddr] <= bus.lut_wdata;
        end
    end

    assign bus.prog_ctr = pc_q;
    assign bus.one_q    = one_q;
    assign bus.pari_q   = pari_q;
    assign bus.sc_q     = sc_q;
    assign bus.busy     = (state_q == StRun);
    assign bus.done     = (state_q == StDone);
    assign bus.timeout  = timeout_q;
endmodule

// File: tb/tb_x9_run_sequencer.sv
// Scoreboard bench for x9_run_sequencer: directed scenarios then randomized traffic against a
// behavioural model; expected outputs are queued per cycle and checked by an independent monitor.
module tb_x9_run_sequencer;
    localparam int D  = 12;
    localparam int LW = 4;
    localparam int WD = 10;
    localparam int NL = 16;
    localparam int PcMod = 4096;
`ifdef X9_WATCHDOG_EN
    localparam bit WdEn = 1'b1;
`else
    localparam bit WdEn = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;

    x9_run_sequencer_if #(.D(D), .LW(LW)) bus ();

    x9_run_sequencer #(.D(D), .LW(LW), .WD_MAX(WD)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [11:0] pc;
        logic        one;
        logic        pari;
        logic        sc;
        logic        busy;
        logic        done;
        logic        timeout;
    } obs_t;

    obs_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    // Behavioural model: mode 0 idle, 1 run, 2 done.
    int m_mode, m_pc, m_wd;
    bit m_one, m_pari, m_sc, m_to;
    int m_lut[NL];

    function automatic void model_step();
        int nxt;
        if (reset) begin
            m_mode = 0; m_pc = 0; m_wd = 0;
            m_one = 0; m_pari = 0; m_sc = 0; m_to = 0;
            for (int i = 0; i < NL; i++) m_lut[i] = 0;
        end else begin
            case (m_mode)
                0: if (bus.req) begin
                    m_mode = 1; m_pc = int'(bus.start_addr); m_wd = 0;
                    m_one = 0; m_pari = 0; m_sc = 0; m_to = 0;
                end
                1: begin
                    nxt = m_pc;
                    if (m_pc == int'(bus.halt_addr)) begin
                        m_mode = 2;
                    end else if (!bus.stall) begin
                        m_wd = m_wd + 1;
                        if (WdEn && m_wd == WD) begin
                            m_mode = 2; m_to = 1;
                        end else if (bus.abs_en && m_one) begin
                            nxt = m_lut[bus.lut_idx];
                        end else if (bus.rel_en && m_one) begin
                            nxt = (m_pc + int'(bus.rel_off)) % PcMod;
                        end else begin
                            nxt = (m_pc + 1) % PcMod;
                        end
                    end
                    if (!bus.stall) begin
                        m_one = bus.one_in; m_pari = bus.pari_in;
                        if (bus.sc_clr) m_sc = 0;
                        else if (bus.sc_en) m_sc = bus.sc_in;
                    end
                    m_pc = nxt;
                end
                default: if (!bus.req) begin
                    m_mode = 0; m_to = 0;
                end
            endcase
            if (bus.lut_we) m_lut[bus.lut_waddr] = int'(bus.lut_wdata);
        end
        exp_q.push_back({12'(m_pc), m_one, m_pari, m_sc, m_mode == 1, m_mode == 2, m_to});
    endfunction

    // Called at a negedge with inputs already driven.
    task automatic step();
        model_step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic clear_in();
        reset = 1'b0;
        bus.req = 0; bus.start_addr = '0; bus.halt_addr = '0; bus.stall = 0;
        bus.abs_en = 0; bus.rel_en = 0; bus.lut_idx = '0; bus.rel_off = '0;
        bus.one_in = 0; bus.pari_in = 0; bus.sc_in = 0; bus.sc_en = 0; bus.sc_clr = 0;
        bus.lut_we = 0; bus.lut_waddr = '0; bus.lut_wdata = '0;
    endtask

    task automatic start_run(input int s, input int h);
        bus.req = 1; bus.start_addr = D'(s); bus.halt_addr = D'(h);
    endtask

    initial begin : monitor
        obs_t e, a;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = {bus.prog_ctr, bus.one_q, bus.pari_q, bus.sc_q, bus.busy, bus.done,
                     bus.timeout};
                checks++;
                if (a !== e) begin
                    failures++;
                    $display("FAIL outputs t=%0t: got pc=%h one=%b pari=%b sc=%b busy=%b done=%b to=%b, expected pc=%h one=%b pari=%b sc=%b busy=%b done=%b to=%b",
                             $time, a.pc, a.one, a.pari, a.sc, a.busy, a.done, a.timeout,
                             e.pc, e.one, e.pari, e.sc, e.busy, e.done, e.timeout);
                end
            end
        end
    end

    initial begin : driver
        clear_in();
        reset = 1'b1;
        @(negedge clk);
        step(); step();
        reset = 1'b0;

        // Straight-line run 0..5, done at the 7th edge, then back to idle.
        start_run(0, 5);
        repeat (8) step();
        bus.req = 0; repeat (2) step();

        // Absolute branch through LUT[3]; first RUN cycle has one_q=0 and falls through.
        bus.lut_we = 1; bus.lut_waddr = 3; bus.lut_wdata = 'h040; step();
        bus.lut_we = 0;
        start_run(2, 'h041); bus.one_in = 1; bus.abs_en = 1; bus.lut_idx = 3;
        repeat (3) step();
        bus.abs_en = 0; repeat (4) step();
        bus.req = 0; repeat (2) step();

        // Relative branch by -2, absolute wins when both are requested.
        start_run('h00F, 'h00E); bus.rel_en = 1; bus.rel_off = 'hFFE;
        repeat (4) step();
        bus.rel_en = 0; bus.req = 0; repeat (2) step();
        bus.lut_we = 1; bus.lut_waddr = 5; bus.lut_wdata = 'h300; step();
        bus.lut_we = 0;
        start_run('h100, 'h300); bus.abs_en = 1; bus.rel_en = 1; bus.lut_idx = 5;
        bus.rel_off = 'h010;
        repeat (3) step();
        bus.abs_en = 0; bus.rel_en = 0; step();
        bus.req = 0; repeat (2) step();

        // PC wrap FFF -> 000.
        start_run('hFFE, 2); bus.one_in = 0;
        repeat (7) step();
        bus.req = 0; repeat (2) step();

        // Stall at PC=4 with toggling flags, sc controls exercised.
        start_run(0, 6); bus.sc_en = 1; bus.sc_in = 1;
        repeat (5) step();
        bus.stall = 1;
        for (int i = 0; i < 3; i++) begin
            bus.one_in = ~bus.one_in; bus.pari_in = ~bus.pari_in; bus.sc_clr = 1; step();
        end
        bus.stall = 0; bus.sc_clr = 0;
        repeat (4) step();
        bus.req = 0; repeat (2) step();

        // start == halt, then hold req in DONE for a while.
        start_run(9, 9);
        repeat (4) step();
        bus.req = 0; repeat (2) step();

        // Reset mid-run at PC=7, then the LUT must read back zero.
        bus.lut_we = 1; bus.lut_waddr = 3; bus.lut_wdata = 'h040; step();
        bus.lut_we = 0; bus.sc_en = 0;
        start_run(0, 'h800);
        repeat (8) step();
        reset = 1; step();
        reset = 0; bus.req = 0; repeat (2) step();
        start_run(2, 5); bus.one_in = 1; bus.abs_en = 1; bus.lut_idx = 3;
        repeat (3) step();
        bus.abs_en = 0; repeat (6) step();
        bus.req = 0; repeat (2) step();

        // Randomized traffic.
        clear_in();
        for (int n = 0; n < 3000; n++) begin
            reset       = ($urandom_range(0, 199) == 0);
            bus.req     = ($urandom_range(0, 7) != 0);
            if (m_mode != 1) begin
                bus.start_addr = D'($urandom);
                bus.halt_addr  = D'(int'(bus.start_addr) + $urandom_range(0, 12));
            end
            bus.stall     = ($urandom_range(0, 3) == 0);
            bus.abs_en    = ($urandom_range(0, 7) == 0);
            bus.rel_en    = ($urandom_range(0, 7) == 0);
            bus.lut_idx   = LW'($urandom);
            bus.rel_off   = D'($urandom_range(0, 6) - 3);
            bus.one_in    = 1'($urandom);
            bus.pari_in   = 1'($urandom);
            bus.sc_in     = 1'($urandom);
            bus.sc_en     = 1'($urandom);
            bus.sc_clr    = ($urandom_range(0, 3) == 0);
            bus.lut_we    = ($urandom_range(0, 3) == 0);
            bus.lut_waddr = LW'($urandom);
            bus.lut_wdata = D'($urandom);
            step();
        end

        clear_in();
        repeat (2) @(posedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: got %0d pending expectations, expected 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
